// File: rtl/multicycle_control_fsm_pkg.sv
// Shared definitions for the multi-cycle RV32I control unit.
//   - RV32I major opcode constants (IR[6:0])
//   - FSM state encoding
//   - alu_ctrl_op class codes and alu_src_b select codes
//   - packed control bundle produced by the output decoder
//   - ID-stage dispatch helper shared by next-state and output decode
package multicycle_control_fsm_pkg;

   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

   typedef enum logic [3:0] {
      S_IF      = 4'd0,
      S_ID      = 4'd1,
      S_EX_ALU  = 4'd2,
      S_WB_ALU  = 4'd3,
      S_EX_ADDR = 4'd4,
      S_MEM_LD  = 4'd5,
      S_WB_LD   = 4'd6,
      S_MEM_ST  = 4'd7,
      S_EX_BR   = 4'd8,
      S_BR_TGT  = 4'd9,
      S_EX_JAL  = 4'd10,
      S_EX_JALR = 4'd11,
      S_HALT    = 4'd12
   } state_t;

   typedef enum logic [1:0] {
      ALU_ADD    = 2'b00,
      ALU_BRANCH = 2'b01,
      ALU_FUNCT  = 2'b10,
      ALU_JALR   = 2'b11
   } alu_op_t;

   typedef enum logic [1:0] {
      SRC_B_REG  = 2'd0,
      SRC_B_FOUR = 2'd1,
      SRC_B_IMM  = 2'd2
   } src_b_t;

   typedef struct packed {
      logic    pc_write;
      logic    pc_source;
      logic    ir_write;
      logic    i_or_d;
      logic    mem_read;
      logic    mem_write;
      logic    mem_to_reg;
      logic    reg_write;
      logic    alu_src_a;
      src_b_t  alu_src_b;
      alu_op_t alu_ctrl_op;
      logic    halted;
   } ctrl_t;

   // Successor of ID. S_IF means "skip": PC+4 is committed in ID itself.
   function automatic state_t id_dispatch(input logic [6:0] opcode,
                                          input logic       is_halt_req);
      state_t nxt;
      case (opcode)
         OPC_OP, OPC_OP_IMM:    nxt = S_EX_ALU;
         OPC_LOAD, OPC_STORE:   nxt = S_EX_ADDR;
         OPC_BRANCH:            nxt = S_EX_BR;
         OPC_JAL:               nxt = S_EX_JAL;
         OPC_JALR:              nxt = S_EX_JALR;
         OPC_SYSTEM:            nxt = is_halt_req ? S_HALT : S_IF;
         default:               nxt = S_IF;
      endcase
      return nxt;
   endfunction

endpackage

// File: rtl/multicycle_control_fsm_outputs.sv
// control_fsm_outputs: pure combinational state-to-control decoder.
// Ports:
//   state        in   current FSM state
//   opcode       in   IR[6:0] of the latched instruction
//   is_halt_req  in   ECALL qualifier (x17 == 10)
//   bcond        in   branch-condition result
//   mem_ready    in   memory completes the current access this cycle
//   ctrl         out  full datapath control bundle for this cycle
module control_fsm_outputs
   import multicycle_control_fsm_pkg::*;
(
   input  state_t      state,
   input  logic [6:0]  opcode,
   input  logic        is_halt_req,
   input  logic        bcond,
   input  logic        mem_ready,
   output ctrl_t       ctrl
);

   always_comb begin
      ctrl = '0;
      case (state)
         S_IF: begin
            ctrl.mem_read = 1'b1;
            ctrl.ir_write = mem_ready;
         end
         S_ID: begin
            // ALUOut <= PC+4; a skipped instruction commits that same sum now
            ctrl.alu_src_b   = SRC_B_FOUR;
            ctrl.alu_ctrl_op = ALU_ADD;
            ctrl.pc_write    = (id_dispatch(opcode, is_halt_req) == S_IF);
         end
         S_EX_ALU: begin
            ctrl.alu_src_a   = 1'b1;
            ctrl.alu_src_b   = (opcode == OPC_OP_IMM) ? SRC_B_IMM : SRC_B_REG;
            ctrl.alu_ctrl_op = ALU_FUNCT;
         end
         S_WB_ALU, S_WB_LD: begin
            ctrl.reg_write   = 1'b1;
            ctrl.mem_to_reg  = (state == S_WB_LD);
            ctrl.alu_src_b   = SRC_B_FOUR;
            ctrl.alu_ctrl_op = ALU_ADD;
            ctrl.pc_write    = 1'b1;
         end
         S_EX_ADDR: begin
            ctrl.alu_src_a   = 1'b1;
            ctrl.alu_src_b   = SRC_B_IMM;
            ctrl.alu_ctrl_op = ALU_ADD;
         end
         S_MEM_LD: begin
            ctrl.i_or_d   = 1'b1;
            ctrl.mem_read = 1'b1;
         end
         S_MEM_ST: begin
            ctrl.i_or_d      = 1'b1;
            ctrl.mem_write   = 1'b1;
            ctrl.alu_src_b   = SRC_B_FOUR;
            ctrl.alu_ctrl_op = ALU_ADD;
            ctrl.pc_write    = mem_ready;
         end
         S_EX_BR: begin
            // not taken: ALUOut still holds PC+4 from ID
            ctrl.alu_src_a   = 1'b1;
            ctrl.alu_src_b   = SRC_B_REG;
            ctrl.alu_ctrl_op = ALU_BRANCH;
            ctrl.pc_source   = ~bcond;
            ctrl.pc_write    = ~bcond;
         end
         S_BR_TGT: begin
            ctrl.alu_src_b   = SRC_B_IMM;
            ctrl.alu_ctrl_op = ALU_ADD;
            ctrl.pc_write    = 1'b1;
         end
         S_EX_JAL: begin
            ctrl.reg_write   = 1'b1;
            ctrl.alu_src_b   = SRC_B_IMM;
            ctrl.alu_ctrl_op = ALU_ADD;
            ctrl.pc_write    = 1'b1;
         end
         S_EX_JALR: begin
            ctrl.reg_write   = 1'b1;
            ctrl.alu_src_a   = 1'b1;
            ctrl.alu_src_b   = SRC_B_IMM;
            ctrl.alu_ctrl_op = ALU_JALR;
            ctrl.pc_write    = 1'b1;
         end
         S_HALT: begin
            ctrl.halted = 1'b1;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/multicycle_control_fsm.sv
// multicycle_control_fsm: control unit for the multi-cycle RV32I datapath.
// Sequences fetch/decode/execute/memory/write-back over a shared ALU and a
// unified memory with a ready handshake.
// Ports:
//   clk, reset                  clock (rising edge), async active-high reset
//   opcode, is_halt_req, bcond  instruction / datapath status
//   mem_ready                   memory access completes this cycle
//   pc_write, pc_source         PC load enable / source select
//   ir_write, i_or_d            IR+MDR load enable / memory address select
//   mem_read, mem_write         memory requests
//   mem_to_reg, reg_write       regfile write data select / enable
//   alu_src_a, alu_src_b        ALU operand selects
//   alu_ctrl_op                 ALU class code for the ALU control decoder
//   halted                      core halted
//   state                       current state, for debug
module multicycle_control_fsm
   import multicycle_control_fsm_pkg::*;
#(
   parameter int STATE_W = 4
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [6:0]         opcode,
   input  logic               is_halt_req,
   input  logic               bcond,
   input  logic               mem_ready,
   output logic               pc_write,
   output logic               pc_source,
   output logic               ir_write,
   output logic               i_or_d,
   output logic               mem_read,
   output logic               mem_write,
   output logic               mem_to_reg,
   output logic               reg_write,
   output logic               alu_src_a,
   output logic [1:0]         alu_src_b,
   output logic [1:0]         alu_ctrl_op,
   output logic               halted,
   output logic [STATE_W-1:0] state
);

   state_t cur_state;
   ctrl_t  dec_ctrl;
   ctrl_t  ctrl;

   control_fsm_outputs u_outputs (
      .state       (cur_state),
      .opcode      (opcode),
      .is_halt_req (is_halt_req),
      .bcond       (bcond),
      .mem_ready   (mem_ready),
      .ctrl        (dec_ctrl)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cur_state <= S_IF;
      end else begin
         case (cur_state)
            S_IF:      if (mem_ready) cur_state <= S_ID;
            S_ID:      cur_state <= id_dispatch(opcode, is_halt_req);
            S_EX_ALU:  cur_state <= S_WB_ALU;
            S_EX_ADDR: cur_state <= (opcode == OPC_LOAD) ? S_MEM_LD : S_MEM_ST;
            S_MEM_LD:  if (mem_ready) cur_state <= S_WB_LD;
            S_MEM_ST:  if (mem_ready) cur_state <= S_IF;
            S_EX_BR:   cur_state <= bcond ? S_BR_TGT : S_IF;
            S_HALT:    cur_state <= S_HALT;
            S_WB_ALU, S_WB_LD, S_BR_TGT, S_EX_JAL, S_EX_JALR:
                       cur_state <= S_IF;
            default:   cur_state <= S_IF;
         endcase
      end
   end

   // IF decodes mem_read=1, so outputs are also gated combinationally:
   // everything is quiet for as long as reset is held, not just after it.
   assign ctrl = reset ? '0 : dec_ctrl;

   assign pc_write    = ctrl.pc_write;
   assign pc_source   = ctrl.pc_source;
   assign ir_write    = ctrl.ir_write;
   assign i_or_d      = ctrl.i_or_d;
   assign mem_read    = ctrl.mem_read;
   assign mem_write   = ctrl.mem_write;
   assign mem_to_reg  = ctrl.mem_to_reg;
   assign reg_write   = ctrl.reg_write;
   assign alu_src_a   = ctrl.alu_src_a;
   assign alu_src_b   = ctrl.alu_src_b;
   assign alu_ctrl_op = ctrl.alu_ctrl_op;
   assign halted      = ctrl.halted;
   assign state       = STATE_W'(cur_state);

endmodule

// File: tb/tb_multicycle_control_fsm.sv
module tb_multicycle_control_fsm;
   import multicycle_control_fsm_pkg::*;

   logic       clk = 1'b0;
   logic       reset;
   logic [6:0] opcode;
   logic       is_halt_req, bcond, mem_ready;
   logic       pc_write, pc_source, ir_write, i_or_d, mem_read, mem_write;
   logic       mem_to_reg, reg_write, alu_src_a, halted;
   logic [1:0] alu_src_b, alu_ctrl_op;
   logic [3:0] state;

   int vectors = 0;
   int miscompares = 0;

   logic [17:0] IFW, IFR, IDN, IDS, EXADDR, WBALU;

   multicycle_control_fsm #(.STATE_W(4)) dut (
      .clk(clk), .reset(reset), .opcode(opcode), .is_halt_req(is_halt_req),
      .bcond(bcond), .mem_ready(mem_ready), .pc_write(pc_write),
      .pc_source(pc_source), .ir_write(ir_write), .i_or_d(i_or_d),
      .mem_read(mem_read), .mem_write(mem_write), .mem_to_reg(mem_to_reg),
      .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
      .alu_ctrl_op(alu_ctrl_op), .halted(halted), .state(state)
   );

   always #5 clk = ~clk;

   // expected vector: state, pcw, pcs, irw, iod, mrd, mwr, m2r, rw, srca, srcb, op, halted
   function automatic logic [17:0] ev(input state_t st, input int pcw, input int pcs,
                                      input int irw, input int iod, input int mr,
                                      input int mw, input int m2r, input int rw,
                                      input int sa, input int sb, input int op,
                                      input int h);
      return {st, 1'(pcw), 1'(pcs), 1'(irw), 1'(iod), 1'(mr), 1'(mw), 1'(m2r),
              1'(rw), 1'(sa), 2'(sb), 2'(op), 1'(h)};
   endfunction

   function automatic logic [17:0] obs();
      return {state, pc_write, pc_source, ir_write, i_or_d, mem_read, mem_write,
              mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_ctrl_op, halted};
   endfunction

   task automatic test_reset();
      reset = 1'b1; opcode = OPC_OP; is_halt_req = 1'b0; bcond = 1'b0; mem_ready = 1'b1;
      #2;
      vectors++;
      if (obs() !== 18'h0) begin
         miscompares++; $display("FAIL reset_async: got %h expected %h", obs(), 18'h0);
      end
      @(posedge clk); #1;
      vectors++;
      if (obs() !== 18'h0) begin
         miscompares++; $display("FAIL reset_held: got %h expected %h", obs(), 18'h0);
      end
      reset = 1'b0; mem_ready = 1'b0;
      #1;
      vectors++;
      if (obs() !== IFW) begin
         miscompares++; $display("FAIL reset_release: got %h expected %h", obs(), IFW);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_alu();
      logic [17:0] exp [9];
      logic [6:0]  opc [9];
      logic        rdy [9];
      exp = '{IFR, IDN, ev(S_EX_ALU,0,0,0,0,0,0,0,0,1,0,2,0), WBALU,
              IFR, IDN, ev(S_EX_ALU,0,0,0,0,0,0,0,0,1,2,2,0), WBALU, IFW};
      opc = '{OPC_OP, OPC_OP, OPC_OP, OPC_OP, OPC_OP_IMM, OPC_OP_IMM,
              OPC_OP_IMM, OPC_OP_IMM, OPC_OP_IMM};
      rdy = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
      is_halt_req = 1'b0; bcond = 1'b0;
      for (int c = 0; c < 9; c++) begin
         opcode = opc[c]; mem_ready = rdy[c];
         #1;
         vectors++;
         if (obs() !== exp[c]) begin
            miscompares++; $display("FAIL alu cycle %0d: got %h expected %h", c, obs(), exp[c]);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_load();
      logic [17:0] exp [8];
      logic        rdy [8];
      logic [17:0] mld;
      mld = ev(S_MEM_LD,0,0,0,1,1,0,0,0,0,0,0,0);
      exp = '{IFR, IDN, EXADDR, mld, mld, mld,
              ev(S_WB_LD,1,0,0,0,0,0,1,1,0,1,0,0), IFW};
      rdy = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
      opcode = OPC_LOAD; is_halt_req = 1'b0; bcond = 1'b0;
      for (int c = 0; c < 8; c++) begin
         mem_ready = rdy[c];
         #1;
         vectors++;
         if (obs() !== exp[c]) begin
            miscompares++; $display("FAIL load cycle %0d: got %h expected %h", c, obs(), exp[c]);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_store();
      logic [17:0] exp [7];
      logic        rdy [7];
      exp = '{IFW, IFR, IDN, EXADDR, ev(S_MEM_ST,0,0,0,1,0,1,0,0,0,1,0,0),
              ev(S_MEM_ST,1,0,0,1,0,1,0,0,0,1,0,0), IFW};
      rdy = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
      opcode = OPC_STORE; is_halt_req = 1'b0; bcond = 1'b0;
      for (int c = 0; c < 7; c++) begin
         mem_ready = rdy[c];
         #1;
         vectors++;
         if (obs() !== exp[c]) begin
            miscompares++; $display("FAIL store cycle %0d: got %h expected %h", c, obs(), exp[c]);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_branch();
      logic [17:0] exp [8];
      logic        bc  [8];
      exp = '{IFR, IDN, ev(S_EX_BR,1,1,0,0,0,0,0,0,1,0,1,0),
              IFR, IDN, ev(S_EX_BR,0,0,0,0,0,0,0,0,1,0,1,0),
              ev(S_BR_TGT,1,0,0,0,0,0,0,0,0,2,0,0), IFW};
      bc = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
      opcode = OPC_BRANCH; is_halt_req = 1'b0;
      for (int c = 0; c < 8; c++) begin
         bcond = bc[c]; mem_ready = (c != 7);
         #1;
         vectors++;
         if (obs() !== exp[c]) begin
            miscompares++; $display("FAIL branch cycle %0d: got %h expected %h", c, obs(), exp[c]);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_jump();
      logic [17:0] exp [7];
      logic [6:0]  opc [7];
      exp = '{IFR, IDN, ev(S_EX_JAL,1,0,0,0,0,0,0,1,0,2,0,0),
              IFR, IDN, ev(S_EX_JALR,1,0,0,0,0,0,0,1,1,2,3,0), IFW};
      opc = '{OPC_JAL, OPC_JAL, OPC_JAL, OPC_JALR, OPC_JALR, OPC_JALR, OPC_JALR};
      is_halt_req = 1'b0; bcond = 1'b0;
      for (int c = 0; c < 7; c++) begin
         opcode = opc[c]; mem_ready = (c != 6);
         #1;
         vectors++;
         if (obs() !== exp[c]) begin
            miscompares++; $display("FAIL jump cycle %0d: got %h expected %h", c, obs(), exp[c]);
         end
         @(posedge clk); #1;
      end
   endtask

   // ecall without halt request, FENCE (unhandled), and an unknown opcode
   // with is_halt_req set: all three retire as PC+4 in ID
   task automatic test_skip();
      logic [17:0] exp [7];
      logic [6:0]  opc [7];
      logic        hr  [7];
      exp = '{IFR, IDS, IFR, IDS, IFR, IDS, IFW};
      opc = '{OPC_SYSTEM, OPC_SYSTEM, 7'b0001111, 7'b0001111, 7'b0000000, 7'b0000000, 7'b0000000};
      hr  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
      bcond = 1'b0;
      for (int c = 0; c < 7; c++) begin
         opcode = opc[c]; is_halt_req = hr[c]; mem_ready = (c != 6);
         #1;
         vectors++;
         if (obs() !== exp[c]) begin
            miscompares++; $display("FAIL skip cycle %0d: got %h expected %h", c, obs(), exp[c]);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_halt();
      logic [17:0] hv;
      hv = ev(S_HALT,0,0,0,0,0,0,0,0,0,0,0,1);
      opcode = OPC_SYSTEM; is_halt_req = 1'b1; bcond = 1'b0; mem_ready = 1'b1;
      #1;
      vectors++;
      if (obs() !== IFR) begin
         miscompares++; $display("FAIL halt_if: got %h expected %h", obs(), IFR);
      end
      @(posedge clk); #1;
      vectors++;
      if (obs() !== IDN) begin
         miscompares++; $display("FAIL halt_id: got %h expected %h", obs(), IDN);
      end
      @(posedge clk); #1;
      for (int c = 0; c < 20; c++) begin
         mem_ready = c[0]; bcond = ~c[0]; is_halt_req = c[1];
         opcode = c[2] ? OPC_OP : OPC_SYSTEM;
         #1;
         vectors++;
         if (obs() !== hv) begin
            miscompares++; $display("FAIL halt_hold cycle %0d: got %h expected %h", c, obs(), hv);
         end
         @(posedge clk); #1;
      end
      reset = 1'b1;
      #1;
      vectors++;
      if (obs() !== 18'h0) begin
         miscompares++; $display("FAIL halt_reset: got %h expected %h", obs(), 18'h0);
      end
      @(posedge clk); #1;
      reset = 1'b0; mem_ready = 1'b0;
      #1;
      vectors++;
      if (obs() !== IFW) begin
         miscompares++; $display("FAIL halt_exit: got %h expected %h", obs(), IFW);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_reset_mid_store();
      logic [17:0] mstw;
      mstw = ev(S_MEM_ST,0,0,0,1,0,1,0,0,0,1,0,0);
      opcode = OPC_STORE; is_halt_req = 1'b0; bcond = 1'b0; mem_ready = 1'b1;
      repeat (3) begin
         @(posedge clk); #1;
      end
      mem_ready = 1'b0;
      #1;
      vectors++;
      if (obs() !== mstw) begin
         miscompares++; $display("FAIL rst_st_before: got %h expected %h", obs(), mstw);
      end
      #2;
      reset = 1'b1;
      #0.5;
      vectors++;
      if (mem_write !== 1'b0 || obs() !== 18'h0) begin
         miscompares++; $display("FAIL rst_st_immediate: got %h expected %h", obs(), 18'h0);
      end
      @(posedge clk); #1;
      reset = 1'b0;
      #1;
      vectors++;
      if (obs() !== IFW) begin
         miscompares++; $display("FAIL rst_st_release: got %h expected %h", obs(), IFW);
      end
      @(posedge clk); #1;
      vectors++;
      if (obs() !== IFW) begin
         miscompares++; $display("FAIL rst_st_idle: got %h expected %h", obs(), IFW);
      end
   endtask

   initial begin
      IFW    = ev(S_IF,0,0,0,0,1,0,0,0,0,0,0,0);
      IFR    = ev(S_IF,0,0,1,0,1,0,0,0,0,0,0,0);
      IDN    = ev(S_ID,0,0,0,0,0,0,0,0,0,1,0,0);
      IDS    = ev(S_ID,1,0,0,0,0,0,0,0,0,1,0,0);
      EXADDR = ev(S_EX_ADDR,0,0,0,0,0,0,0,0,1,2,0,0);
      WBALU  = ev(S_WB_ALU,1,0,0,0,0,0,0,1,0,1,0,0);
      test_reset();
      test_alu();
      test_load();
      test_store();
      test_branch();
      test_jump();
      test_skip();
      test_halt();
      test_reset_mid_store();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
